// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl
// Purpose  : 2-entry fetch-to-decode buffer with immediate-format decode and
//            load-use hazard stall detection.
// Revision : 1.0  initial release
// ============================================================================
module decode_ctrl #(
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            if_inst,
  input  logic [31:0]            if_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_inst,
  output logic [31:0]            id_pc,
  output logic [2:0]             imm_type,
  input  logic                   flush,
  input  logic                   ex_load,
  input  logic [4:0]             ex_rd,
  output logic                   hazard,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_ari_i  = 7'b0010011;
  localparam logic [6:0] c_op_ari_r  = 7'b0110011;
  localparam logic [6:0] c_op_csr    = 7'b1110011;

  localparam logic [2:0] c_imm_i    = 3'd0;
  localparam logic [2:0] c_imm_s    = 3'd1;
  localparam logic [2:0] c_imm_b    = 3'd2;
  localparam logic [2:0] c_imm_u    = 3'd3;
  localparam logic [2:0] c_imm_j    = 3'd4;
  localparam logic [2:0] c_imm_z    = 3'd5;
  localparam logic [2:0] c_imm_none = 3'd7;

  localparam logic [1:0]             c_full      = 2'd2;
  localparam logic [STALL_CNT_W-1:0] c_stall_max = '1;
  localparam logic [STALL_CNT_W-1:0] c_stall_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]            r_inst [2];
  logic [31:0]            r_pc   [2];
  logic                   r_head;
  logic                   r_tail;
  logic [1:0]             r_count;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic        w_not_empty;
  logic [31:0] w_head_inst;
  logic [31:0] w_head_pc;
  logic [6:0]  w_opcode;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_rs1_match;
  logic        w_rs2_match;
  logic        w_hazard;
  logic        w_id_valid;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_imm_type;

  assign w_not_empty = (r_count != 2'd0);
  assign w_head_inst = r_inst[r_head];
  assign w_head_pc   = r_pc[r_head];
  assign w_opcode    = w_head_inst[6:0];

  // Register-use decode of the head; CSR immediate forms (funct3[2]) read no rs1.
  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      c_op_jalr,
      c_op_load,
      c_op_ari_i:  w_uses_rs1 = 1'b1;
      c_op_branch,
      c_op_store,
      c_op_ari_r: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      c_op_csr:    w_uses_rs1 = ~w_head_inst[14];
      default: begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_imm_type = c_imm_none;
    if (w_not_empty) begin
      case (w_opcode)
        c_op_lui,
        c_op_auipc:  w_imm_type = c_imm_u;
        c_op_jal:    w_imm_type = c_imm_j;
        c_op_branch: w_imm_type = c_imm_b;
        c_op_store:  w_imm_type = c_imm_s;
        c_op_csr:    w_imm_type = c_imm_z;
        c_op_load,
        c_op_jalr,
        c_op_ari_i:  w_imm_type = c_imm_i;
        default:     w_imm_type = c_imm_none;
      endcase
    end
  end

  assign w_rs1_match = w_uses_rs1 && (w_head_inst[19:15] == ex_rd);
  assign w_rs2_match = w_uses_rs2 && (w_head_inst[24:20] == ex_rd);
  assign w_hazard    = w_not_empty && ex_load && (ex_rd != 5'd0) &&
                       (w_rs1_match || w_rs2_match);

  assign w_id_valid  = w_not_empty && !w_hazard && !flush;
  assign w_push      = if_valid && if_ready && !flush;
  assign w_pop       = w_id_valid && id_ready;

  // Fetch handshake depends only on registered occupancy.
  assign if_ready  = (r_count != c_full);
  assign id_valid  = w_id_valid;
  assign id_inst   = w_not_empty ? w_head_inst : NOP_INST;
  assign id_pc     = w_not_empty ? w_head_pc : 32'd0;
  assign imm_type  = w_imm_type;
  assign hazard    = w_hazard;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Payload storage needs no reset: it is only observed through r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_tail] <= if_inst;
      r_pc[r_tail]   <= if_pc;
    end
  end

  // A flush cycle is not counted as a stall even if the head looked hazardous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !flush && (r_stall_cnt != c_stall_max)) begin
      r_stall_cnt <= r_stall_cnt + c_stall_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_ctrl
// Purpose  : Self-checking bench for decode_ctrl against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_ctrl;

  localparam int          SW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_valid = 1'b0;
  logic          if_ready;
  logic [31:0]   if_inst = '0;
  logic [31:0]   if_pc = '0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_inst;
  logic [31:0]   id_pc;
  logic [2:0]    imm_type;
  logic          flush = 1'b0;
  logic          ex_load = 1'b0;
  logic [4:0]    ex_rd = '0;
  logic          hazard;
  logic [SW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q[$];
  int          m_stall = 0;

  decode_ctrl #(.NOP_INST(NOP), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .imm_type(imm_type), .flush(flush), .ex_load(ex_load), .ex_rd(ex_rd),
    .hazard(hazard), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_imm(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17:        return 3'd3;
      7'h6f:               return 3'd4;
      7'h63:               return 3'd2;
      7'h23:               return 3'd1;
      7'h73:               return 3'd5;
      7'h03, 7'h67, 7'h13: return 3'd0;
      default:             return 3'd7;
    endcase
  endfunction

  // Registers the instruction reads: bit0 = rs1, bit1 = rs2.
  function automatic logic [1:0] m_reads(input logic [31:0] i);
    case (i[6:0])
      7'h67, 7'h03, 7'h13: return 2'b01;
      7'h63, 7'h23, 7'h33: return 2'b11;
      7'h73:               return {1'b0, ~i[14]};
      default:             return 2'b00;
    endcase
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic ld, input logic [4:0] rd);
    logic        nz, e_haz, e_vld, e_rdy;
    logic [31:0] h_inst, h_pc;
    logic [1:0]  rd_use;
    if_valid = v; if_inst = inst; if_pc = pc;
    id_ready = rdy; flush = fl; ex_load = ld; ex_rd = rd;
    @(negedge clk);
    nz     = (q.size() > 0);
    h_inst = nz ? q[0][31:0] : NOP;
    h_pc   = nz ? q[0][63:32] : 32'd0;
    rd_use = nz ? m_reads(h_inst) : 2'b00;
    e_haz  = nz && ld && (rd != 0) &&
             ((rd_use[0] && h_inst[19:15] == rd) || (rd_use[1] && h_inst[24:20] == rd));
    e_vld  = nz && !e_haz && !fl;
    e_rdy  = (q.size() != 2);
    check("if_ready", {31'd0, if_ready}, {31'd0, e_rdy});
    check("id_valid", {31'd0, id_valid}, {31'd0, e_vld});
    check("hazard",   {31'd0, hazard},   {31'd0, e_haz});
    check("id_inst",  id_inst, h_inst);
    check("id_pc",    id_pc, h_pc);
    check("imm_type", {29'd0, imm_type}, {29'd0, nz ? m_imm(h_inst) : 3'd7});
    check("stall_cnt", {{(32-SW){1'b0}}, stall_cnt}, m_stall);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (e_vld && rdy) void'(q.pop_front());
      if (v && e_rdy)   q.push_back({pc, inst});
    end
    if (e_haz && !fl && m_stall < (1 << SW) - 1) m_stall++;
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, rdy, 1'b0, 1'b0, 5'd0);
  endtask

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};

  initial begin
    // Reset values
    #7;
    check("rst if_ready", {31'd0, if_ready}, 32'd1);
    check("rst id_valid", {31'd0, id_valid}, 32'd0);
    check("rst id_inst",  id_inst, NOP);
    check("rst id_pc",    id_pc, 32'd0);
    check("rst imm_type", {29'd0, imm_type}, 32'd7);
    check("rst hazard",   {31'd0, hazard}, 32'd0);
    check("rst stall",    {{(32-SW){1'b0}}, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single push then pop, first edge after reset release
    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(1'b1);
    idle(1'b1);

    // Fill with downstream blocked, third offer refused, then drain
    step(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Load-use stall on rs1, then release; ex_rd=0 never stalls
    step(1'b1, 32'h00208133, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1);
    check("stall after 2", {{(32-SW){1'b0}}, stall_cnt}, 32'd2);
    idle(1'b1);
    step(1'b1, 32'h00208133, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0);
    idle(1'b1);

    // Flush at full occupancy with a same-cycle push offer
    step(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00300193, 32'h408, 1'b1, 1'b1, 1'b0, 5'd0);
    idle(1'b1);

    // Immediate formats; CSRRWI with matching uimm field must not stall
    step(1'b1, 32'h123450b7, 32'h500, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00112223, 32'h504, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00208463, 32'h508, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h008000ef, 32'h50c, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h3400d073, 32'h510, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    idle(1'b1);

    // Asynchronous reset between edges with two entries held
    step(1'b1, 32'h00100093, 32'h600, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h00200113, 32'h604, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async id_valid", {31'd0, id_valid}, 32'd0);
    check("async if_ready", {31'd0, if_ready}, 32'd1);
    check("async id_inst",  id_inst, NOP);
    q.delete();
    m_stall = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Saturating stall counter
    step(1'b1, 32'h00208133, 32'h700, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2);
    check("stall sat", {{(32-SW){1'b0}}, stall_cnt}, (1 << SW) - 1);
    step(1'b1, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0);
    m_stall = m_stall;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ri;
      ri = {$urandom_range(0, 127), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom), ops[$urandom_range(0, 10)]};
      step(1'($urandom), ri, $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), 1'($urandom), 5'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0013, instruction presented on id_inst when no entry is held.
REQ-002 Parameter STALL_CNT_W, default 16, width of the load-use stall counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 if_valid  input  1  fetch offers an instruction.
REQ-006 if_ready  output  1  decode_ctrl can accept an instruction.
REQ-007 if_inst  input  32  fetched instruction word.
REQ-008 if_pc  input  32  PC of if_inst.
REQ-009 id_valid  output  1  head instruction is issued to decode/immediate generation.
REQ-010 id_ready  input  1  downstream accepts the issued instruction.
REQ-011 id_inst  output  32  head instruction, or NOP_INST when empty.
REQ-012 id_pc  output  32  PC of head, or 0 when empty.
REQ-013 imm_type  output  3  immediate format of head: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR uimm), 7 none.
REQ-014 flush  input  1  redirect; discard all held instructions.
REQ-015 ex_load  input  1  instruction in execute is a valid load.
REQ-016 ex_rd  input  5  destination register of the execute instruction.
REQ-017 hazard  output  1  load-use stall active on head this cycle.
REQ-018 stall_cnt  output  STALL_CNT_W  saturating count of stalled cycles.

Function
REQ-019 Storage SHALL be a 2-entry FIFO (inst, pc), head/tail pointers wrapping modulo 2, occupancy count 0..2.
REQ-020 if_ready SHALL equal (count != 2), from registered state only, no combinational path from id_ready.
REQ-021 Push SHALL occur when if_valid && if_ready && !flush; entry visible at head no earlier than the next cycle (1-cycle latency).
REQ-022 hazard SHALL be 1 when count>0 && ex_load && ex_rd!=0 && ((uses_rs1 && inst[19:15]==ex_rd) || (uses_rs2 && inst[24:20]==ex_rd)).
REQ-023 uses_rs1 SHALL be 1 for opcodes JALR, BRANCH, LOAD, STORE, ARI_ITYPE, ARI_RTYPE, and CSR with funct3[2]==0; 0 otherwise.
REQ-024 uses_rs2 SHALL be 1 for opcodes BRANCH, STORE, ARI_RTYPE only.
REQ-025 id_valid SHALL equal count>0 && !hazard && !flush.
REQ-026 Pop SHALL occur when id_valid && id_ready.
REQ-027 Push and pop in the same cycle at count 1 SHALL leave count 1 with the new entry as head next cycle.
REQ-028 flush SHALL set count to 0 next cycle, ignore same-cycle push and pop, and leave stall_cnt unchanged.
REQ-029 imm_type SHALL decode head inst[6:0]: LUI/AUIPC 3, JAL 4, BRANCH 2, STORE 1, CSR 5, LOAD/JALR/ARI_ITYPE 0, all others or empty 7.
REQ-030 id_inst, id_pc, imm_type, hazard SHALL be combinational from registered head state and ex_* inputs.
REQ-031 stall_cnt SHALL increment by 1 each cycle hazard==1, saturating at 2^STALL_CNT_W-1, never wrapping.
REQ-032 Holding id_ready=0 SHALL keep head, id_inst and id_pc stable until pop or flush.

Reset
REQ-033 While rst_n==0: count 0, pointers 0, stall_cnt 0; hence if_ready 1, id_valid 0, id_inst NOP_INST, id_pc 0, imm_type 7, hazard 0.
REQ-034 Reset asserted mid-operation SHALL discard held entries immediately, independent of clk.
REQ-035 First push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Push 32'h00500093 (addi x1,x0,5) pc 0x100, id_ready=1 -> next cycle id_valid=1, id_pc=0x100, imm_type=0; popped, then id_inst=NOP_INST.
REQ-037 id_ready=0, push 3 instructions back-to-back -> if_ready=0 after 2 accepted, third held by fetch; id_ready=1 -> drains in order, if_ready returns 1.
REQ-038 Head 32'h00208133 (add x2,x1,x2), ex_load=1, ex_rd=1 for 2 cycles -> hazard=1, id_valid=0 both cycles, stall_cnt=2; then id_valid=1. Same with ex_rd=0 -> no hazard.
REQ-039 Count 2, flush=1 with if_valid=1 -> next cycle count 0, id_valid=0, if_ready=1, stall_cnt unchanged.
REQ-040 Heads LUI 32'h123450b7, SW 32'h00112223, BEQ 32'h00208463, JAL 32'h008000ef, CSRRWI 32'h3400d073 -> imm_type 3,1,2,4,5; CSRRWI never raises hazard.
REQ-041 Drive rst_n=0 asynchronously with count 2 between clock edges -> id_valid=0, if_ready=1 immediately.
